// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED panel scan sequencer.
package led_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RRST,
        SHIFT,
        BLANK,
        LATCH
    } scan_state_t;

    localparam int DEF_COLS        = 64;
    localparam int DEF_ROWS        = 16;
    localparam int DEF_PWM_STEPS   = 32;
    localparam int DEF_BLANK_TICKS = 2;

    localparam int ROW_ADDR_W = 4;

    // Counter width that never collapses to zero bits for tiny parameter values.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/led_tick_counter.sv
// Tick-enabled down-counter: loads a start value, steps down once per tick and
// flags the terminal count (zero). Load takes priority over counting.
module led_tick_counter
    import led_scan_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && !tc) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/led_scan_ctrl.sv
// HUB75 scan sequencer paced by the receiver's pixel-pair strobe.
// Optional macro LED_SCAN_BRIGHTNESS_EN adds in_brightness to limit OE on-time per row.
module led_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int COLS        = DEF_COLS,
    parameter int ROWS        = DEF_ROWS,
    parameter int PWM_STEPS   = DEF_PWM_STEPS,
    parameter int BLANK_TICKS = DEF_BLANK_TICKS
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  pwm_cntr_strobe,
    input  logic                  in_run,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [7:0]            in_brightness,
`endif
    output logic [7:0]            pwm_value,
    output logic [ROW_ADDR_W-1:0] row_addr,
    output logic                  led_lat,
    output logic                  led_oe_n,
    output logic                  led_clk_en,
    output logic                  al_rrst_n,
    output logic                  al_re_n,
    output logic                  frame_done
);

    localparam int COL_W = clog2_min1(COLS);
    localparam int ROW_W = clog2_min1(ROWS);
    localparam int BLK_W = clog2_min1(BLANK_TICKS);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLANK_TICKS - 1);
    localparam logic [7:0]       PWM_LAST  = 8'(PWM_STEPS - 1);

    scan_state_t state, state_nxt;

    logic [ROW_W-1:0]      shift_row, shift_row_nxt;
    logic                  shown, shown_nxt;
    logic [7:0]            pwm_nxt;
    logic [ROW_ADDR_W-1:0] row_addr_nxt;
    logic                  lat_nxt;
    logic                  oe_n_nxt;
    logic                  clk_en_nxt;
    logic                  rrst_n_nxt;
    logic                  re_n_nxt;
    logic                  frame_done_nxt;

    logic                  col_load;
    logic                  col_tick;
    logic [COL_W-1:0]      col_count;
    logic                  col_tc;
    logic [COL_W-1:0]      col_idx;
    logic [COL_W-1:0]      col_idx_nxt;

    logic                  blk_load;
    logic                  blk_tick;
    logic [BLK_W-1:0]      blk_count_unused;
    logic                  blk_tc;

    logic                  oe_on;

    // Columns count down from COLS-1, so the shifted column index is the complement.
    assign col_load = pwm_cntr_strobe && (state_nxt == SHIFT) && (state != SHIFT);
    assign col_tick = pwm_cntr_strobe && (state == SHIFT);
    assign col_idx  = COL_LAST - col_count;

    led_tick_counter #(
        .WIDTH (COL_W)
    ) u_col_counter (
        .clk        (in_clk),
        .rst        (in_rst),
        .tick       (col_tick),
        .load       (col_load),
        .load_value (COL_LAST),
        .count      (col_count),
        .tc         (col_tc)
    );

    assign blk_load = pwm_cntr_strobe && (state == SHIFT) && col_tc;
    assign blk_tick = pwm_cntr_strobe && (state == BLANK);

    led_tick_counter #(
        .WIDTH (BLK_W)
    ) u_blank_counter (
        .clk        (in_clk),
        .rst        (in_rst),
        .tick       (blk_tick),
        .load       (blk_load),
        .load_value (BLK_LAST),
        .count      (blk_count_unused),
        .tc         (blk_tc)
    );

    // Column that will be on the shift bus during the tick period being entered.
    assign col_idx_nxt = (state == SHIFT) ? col_idx + 1'b1 : '0;

`ifdef LED_SCAN_BRIGHTNESS_EN
    assign oe_on = (32'(col_idx_nxt) < 32'(in_brightness));
`else
    assign oe_on = 1'b1;
`endif

    always_comb begin
        state_nxt      = state;
        shift_row_nxt  = shift_row;
        shown_nxt      = shown;
        pwm_nxt        = pwm_value;
        row_addr_nxt   = row_addr;
        frame_done_nxt = 1'b0;

        if (pwm_cntr_strobe) begin
            case (state)
                IDLE: begin
                    if (in_run) state_nxt = RRST;
                end
                RRST: begin
                    state_nxt = SHIFT;
                end
                SHIFT: begin
                    if (col_tc) state_nxt = BLANK;
                end
                BLANK: begin
                    if (blk_tc) begin
                        state_nxt    = LATCH;
                        row_addr_nxt = ROW_ADDR_W'(shift_row);
                        shown_nxt    = 1'b1;
                    end
                end
                LATCH: begin
                    if (shift_row == ROW_LAST) begin
                        if (pwm_value == PWM_LAST) begin
                            pwm_nxt        = '0;
                            frame_done_nxt = 1'b1;
                        end else begin
                            pwm_nxt = pwm_value + 8'd1;
                        end
                        state_nxt = in_run ? RRST : IDLE;
                    end else begin
                        shift_row_nxt = shift_row + 1'b1;
                        state_nxt     = in_run ? SHIFT : IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        if (state_nxt == RRST) shift_row_nxt = '0;
        // A restart must not light the panel with whatever row was latched before the stop.
        if (state_nxt == IDLE) shown_nxt = 1'b0;

        lat_nxt    = (state_nxt == LATCH);
        rrst_n_nxt = (state_nxt != RRST);
        re_n_nxt   = (state_nxt != SHIFT);
        clk_en_nxt = (state_nxt == SHIFT);
        oe_n_nxt   = !((state_nxt == SHIFT) && shown_nxt && oe_on);
    end

    // Tick-period outputs only move on a strobe; frame_done is a single-cycle pulse.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state      <= IDLE;
            shift_row  <= '0;
            shown      <= 1'b0;
            pwm_value  <= '0;
            row_addr   <= '0;
            led_lat    <= 1'b0;
            led_oe_n   <= 1'b1;
            led_clk_en <= 1'b0;
            al_rrst_n  <= 1'b1;
            al_re_n    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_done_nxt;
            if (pwm_cntr_strobe) begin
                state      <= state_nxt;
                shift_row  <= shift_row_nxt;
                shown      <= shown_nxt;
                pwm_value  <= pwm_nxt;
                row_addr   <= row_addr_nxt;
                led_lat    <= lat_nxt;
                led_oe_n   <= oe_n_nxt;
                led_clk_en <= clk_en_nxt;
                al_rrst_n  <= rrst_n_nxt;
                al_re_n    <= re_n_nxt;
            end
        end
    end

endmodule
